// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 key-schedule types, constants and S-box lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR = 10;
    localparam int KW = 128;

    typedef logic [127:0] rkey_t;
    typedef logic [7:0]   rcon_t [0:9];

    // Rcon for expansion steps 1..10, stored at index step-1
    localparam rcon_t RCON = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_STREAM = 2'd2
    } ks_state_t;

    // Byte 0x00 sits in the top 8 bits, so byte b lives at offset (255-b)*8
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_step
// Description : Combinational single-round AES-128 key expansion step.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  rkey_t       i_key,
    input  logic [3:0]  i_rnd,
    output rkey_t       o_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;
    logic [7:0]  w_rcon;

    assign w_w0 = i_key[127:96];
    assign w_w1 = i_key[95:64];
    assign w_w2 = i_key[63:32];
    assign w_w3 = i_key[31:0];

    aes_rot_word u_rot (
        .i_word (w_w3),
        .o_word (w_rot)
    );

    aes_sub_word u_sub (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    always_comb begin
        w_rcon = 8'h00;
        if (i_rnd >= 4'd1 && i_rnd <= 4'd10) begin
            w_rcon = RCON[i_rnd - 4'd1];
        end
    end

    assign w_t  = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_rot_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_rot_word
// Description : AES RotWord - cyclic left byte rotation of a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rot_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {i_word[23:0], i_word[31:24]};

endmodule
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_sub_word
// Description : AES SubWord - S-box substitution on each byte of a word.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign o_word[8*g +: 8] = sbox(i_word[8*g +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : AES-128 round-key expander with a cached schedule that is
//               streamed forward or reverse over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_ctrl #(
    parameter int NR = aes_pkg::NR,
    parameter int KW = aes_pkg::KW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [KW-1:0] key,
    input  logic          start,
    input  logic          dir,
    input  logic          rk_ready,
    output logic          rk_valid,
    output logic [KW-1:0] rk,
    output logic [3:0]    rk_round,
    output logic          rk_last,
    output logic          busy,
    output logic          cache_ok
);

    import aes_pkg::*;

    localparam logic [3:0] c_LAST = 4'(NR);

    ks_state_t     r_state;
    logic [KW-1:0] r_cache [0:NR];
    logic [KW-1:0] r_work;
    logic [3:0]    r_cnt;
    logic [3:0]    r_idx;
    logic          r_dir;
    logic          r_rk_valid;
    logic [KW-1:0] r_rk;
    logic [3:0]    r_rk_round;
    logic          r_rk_last;
    logic          r_busy;
    logic          r_cache_ok;

    logic [KW-1:0] w_next_key;
    logic [3:0]    w_idx_first;
    logic [3:0]    w_idx_next;
    logic [3:0]    w_idx_end;

    aes_key_step u_step (
        .i_key (r_work),
        .i_rnd (r_cnt),
        .o_key (w_next_key)
    );

    assign w_idx_first = dir ? c_LAST : 4'd0;
    assign w_idx_next  = r_dir ? (r_idx - 4'd1) : (r_idx + 4'd1);
    assign w_idx_end   = r_dir ? 4'd0 : c_LAST;

    // Schedule storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load) begin
                r_cache[0] <= key;
            end else if (r_state == KS_EXPAND) begin
                r_cache[r_cnt] <= w_next_key;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= KS_IDLE;
            r_work     <= '0;
            r_cnt      <= 4'd0;
            r_idx      <= 4'd0;
            r_dir      <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk       <= '0;
            r_rk_round <= 4'd0;
            r_rk_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_cache_ok <= 1'b0;
        end else if (load) begin
            // A new key overrides whatever is in flight, including a same-cycle start
            r_state    <= KS_EXPAND;
            r_work     <= key;
            r_cnt      <= 4'd1;
            r_cache_ok <= 1'b0;
            r_busy     <= 1'b1;
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
        end else begin
            case (r_state)
                KS_IDLE: begin
                    if (start && r_cache_ok) begin
                        r_state    <= KS_STREAM;
                        r_dir      <= dir;
                        r_idx      <= w_idx_first;
                        r_rk_valid <= 1'b1;
                        r_rk       <= r_cache[w_idx_first];
                        r_rk_round <= w_idx_first;
                        r_rk_last  <= (w_idx_first == (dir ? 4'd0 : c_LAST));
                    end
                end
                KS_EXPAND: begin
                    r_work <= w_next_key;
                    if (r_cnt == c_LAST) begin
                        r_state    <= KS_IDLE;
                        r_busy     <= 1'b0;
                        r_cache_ok <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                KS_STREAM: begin
                    if (rk_ready) begin
                        if (r_rk_last) begin
                            r_state    <= KS_IDLE;
                            r_rk_valid <= 1'b0;
                        end else begin
                            r_idx      <= w_idx_next;
                            r_rk       <= r_cache[w_idx_next];
                            r_rk_round <= w_idx_next;
                            r_rk_last  <= (w_idx_next == w_idx_end);
                        end
                    end
                end
                default: begin
                    r_state <= KS_IDLE;
                end
            endcase
        end
    end

    assign rk_valid = r_rk_valid;
    assign rk       = r_rk;
    assign rk_round = r_rk_round;
    assign rk_last  = r_rk_last;
    assign busy     = r_busy;
    assign cache_ok = r_cache_ok;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Directed self-checking bench for aes_key_sched_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] c_KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_KEY_Z = 128'h0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [127:0] key = '0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic         rk_ready = 1'b0;
    logic         rk_valid;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;
    logic         cache_ok;

    int checks = 0;
    int failures = 0;

    logic [127:0] g_key [0:10];
    logic [3:0]   g_rnd [0:10];
    logic         g_last [0:10];
    int           n_got, cyc, stall_bad, gaps;
    logic         busy_seen, valid_after;

    aes_key_sched_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .key      (key),
        .start    (start),
        .dir      (dir),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_last  (rk_last),
        .busy     (busy),
        .cache_ok (cache_ok)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [127:0] key_a(input int r);
        case (r)
            0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  return 128'ha0fafe1788542cb123a339392a6c7605;
            2:  return 128'hf2c295f27a96b9435935807a7359f67f;
            3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  return 128'head27321b58dbad2312bf5607f8d292f;
            9:  return 128'hac7766f319fadc2128d12941575c006e;
            default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [127:0] kv);
        key  = kv;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_expand(output int k);
        k = 0;
        while (!cache_ok && k < 50) begin
            tick();
            k++;
        end
    endtask

    // Issues start and gathers up to 11 transfers, noting stalls and gaps
    task automatic collect_stream(input logic d, input bit rnd);
        logic         r;
        logic         chk_hold;
        logic [127:0] held_key;
        logic [3:0]   held_rnd;
        dir   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_got = 0; cyc = 0; stall_bad = 0; gaps = 0; busy_seen = 1'b0;
        chk_hold = 1'b0; held_key = '0; held_rnd = '0;
        while (n_got < 11 && cyc < 200) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = r;
            if (busy) busy_seen = 1'b1;
            if (rk_valid && r) begin
                g_key[n_got]  = rk;
                g_rnd[n_got]  = rk_round;
                g_last[n_got] = rk_last;
                n_got++;
            end else if (rk_valid) begin
                held_key = rk;
                held_rnd = rk_round;
                chk_hold = 1'b1;
            end else begin
                gaps++;
            end
            tick();
            cyc++;
            if (chk_hold) begin
                if (!rk_valid || rk !== held_key || rk_round !== held_rnd) stall_bad++;
                chk_hold = 1'b0;
            end
        end
        valid_after = rk_valid;
        rk_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({rk_valid, rk, rk_round, rk_last, busy, cache_ok} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b rk=%h rnd=%0d last=%b busy=%b ok=%b exp all 0",
                     rk_valid, rk, rk_round, rk_last, busy, cache_ok);
        end
    endtask

    task automatic test_start_no_cache();
        dir = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_no_cache got valid=%b busy=%b exp 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_forward();
        int k;
        do_load(c_KEY_A);
        checks++;
        if (busy !== 1'b1 || cache_ok !== 1'b0) begin
            failures++;
            $display("FAIL fwd_busy_after_load got busy=%b ok=%b exp 1 0", busy, cache_ok);
        end
        wait_expand(k);
        checks++;
        if (k !== 10 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fwd_expand_latency got edges=%0d busy=%b exp 10 0", k, busy);
        end
        collect_stream(1'b0, 1'b0);
        checks++;
        if (n_got !== 11 || cyc !== 11 || valid_after !== 1'b0) begin
            failures++;
            $display("FAIL fwd_stream_shape got n=%0d cyc=%0d valid_after=%b exp 11 11 0",
                     n_got, cyc, valid_after);
        end
        for (int i = 0; i < n_got; i++) begin
            checks++;
            if (g_key[i] !== key_a(i) || g_rnd[i] !== 4'(i) || g_last[i] !== (i == 10)) begin
                failures++;
                $display("FAIL fwd_key[%0d] got %h rnd=%0d last=%b exp %h rnd=%0d last=%b",
                         i, g_key[i], g_rnd[i], g_last[i], key_a(i), i, (i == 10));
            end
        end
    endtask

    task automatic test_reverse();
        collect_stream(1'b1, 1'b0);
        checks++;
        if (n_got !== 11 || busy_seen !== 1'b0 || valid_after !== 1'b0) begin
            failures++;
            $display("FAIL rev_stream_shape got n=%0d busy_seen=%b valid_after=%b exp 11 0 0",
                     n_got, busy_seen, valid_after);
        end
        for (int i = 0; i < n_got; i++) begin
            checks++;
            if (g_key[i] !== key_a(10 - i) || g_rnd[i] !== 4'(10 - i) || g_last[i] !== (i == 10)) begin
                failures++;
                $display("FAIL rev_key[%0d] got %h rnd=%0d last=%b exp %h rnd=%0d last=%b",
                         i, g_key[i], g_rnd[i], g_last[i], key_a(10 - i), 10 - i, (i == 10));
            end
        end
    endtask

    task automatic test_back_to_back();
        collect_stream(1'b0, 1'b0);
        collect_stream(1'b1, 1'b0);
        checks++;
        if (n_got !== 11 || gaps !== 0 || g_key[0] !== key_a(10) || g_key[10] !== key_a(0)) begin
            failures++;
            $display("FAIL b2b_second_stream got n=%0d gaps=%0d first=%h last=%h exp 11 0 %h %h",
                     n_got, gaps, g_key[0], g_key[10], key_a(10), key_a(0));
        end
    endtask

    task automatic test_backpressure();
        collect_stream(1'b0, 1'b1);
        checks++;
        if (n_got !== 11 || stall_bad !== 0) begin
            failures++;
            $display("FAIL bp_shape got n=%0d stall_bad=%0d exp 11 0", n_got, stall_bad);
        end
        for (int i = 0; i < n_got; i++) begin
            checks++;
            if (g_key[i] !== key_a(i) || g_rnd[i] !== 4'(i)) begin
                failures++;
                $display("FAIL bp_key[%0d] got %h rnd=%0d exp %h rnd=%0d",
                         i, g_key[i], g_rnd[i], key_a(i), i);
            end
        end
    endtask

    task automatic test_start_during_expand();
        int  k;
        logic seen;
        do_load(c_KEY_A);
        dir = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = rk_valid;
        k = 0;
        while (!cache_ok && k < 50) begin
            tick();
            k++;
            if (rk_valid) seen = 1'b1;
        end
        tick();
        if (rk_valid) seen = 1'b1;
        checks++;
        if (seen !== 1'b0 || cache_ok !== 1'b1) begin
            failures++;
            $display("FAIL start_in_expand got valid_seen=%b ok=%b exp 0 1", seen, cache_ok);
        end
    endtask

    task automatic test_abort();
        int k;
        dir = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        rk_ready = 1'b1;
        repeat (3) tick();
        key  = c_KEY_Z;
        load = 1'b1;
        tick();
        load = 1'b0;
        rk_ready = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b1 || cache_ok !== 1'b0) begin
            failures++;
            $display("FAIL abort_stream got valid=%b busy=%b ok=%b exp 0 1 0", rk_valid, busy, cache_ok);
        end
        wait_expand(k);
        checks++;
        if (k !== 10) begin
            failures++;
            $display("FAIL abort_expand_latency got %0d exp 10", k);
        end
        collect_stream(1'b0, 1'b0);
        checks++;
        if (n_got !== 11 || g_key[0] !== c_KEY_Z
            || g_key[1] !== 128'h62636363626363636263636362636363
            || g_key[2] !== 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa
            || g_key[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            failures++;
            $display("FAIL abort_new_schedule got n=%0d r0=%h r1=%h r2=%h r10=%h exp zero-key schedule",
                     n_got, g_key[0], g_key[1], g_key[2], g_key[10]);
        end
        key   = c_KEY_A;
        load  = 1'b1;
        start = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_start_same got valid=%b busy=%b exp 0 1", rk_valid, busy);
        end
        wait_expand(k);
        collect_stream(1'b0, 1'b0);
        checks++;
        if (k !== 10 || g_key[1] !== key_a(1) || g_key[10] !== key_a(10)) begin
            failures++;
            $display("FAIL load_start_schedule got edges=%0d r1=%h r10=%h exp 10 %h %h",
                     k, g_key[1], g_key[10], key_a(1), key_a(10));
        end
    endtask

    task automatic test_reset_mid_expand();
        int   k;
        logic seen;
        do_load(c_KEY_Z);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({rk_valid, rk, rk_round, rk_last, busy, cache_ok} !== '0) begin
            failures++;
            $display("FAIL reset_mid_expand got valid=%b rk=%h rnd=%0d last=%b busy=%b ok=%b exp all 0",
                     rk_valid, rk, rk_round, rk_last, busy, cache_ok);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = rk_valid;
        repeat (12) begin
            tick();
            if (rk_valid || cache_ok) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored got valid_or_ok_seen=%b exp 0", seen);
        end
        do_load(c_KEY_A);
        wait_expand(k);
        collect_stream(1'b1, 1'b0);
        checks++;
        if (k !== 10 || n_got !== 11 || g_key[0] !== key_a(10) || g_last[10] !== 1'b1) begin
            failures++;
            $display("FAIL reset_reload got edges=%0d n=%0d first=%h last=%b exp 10 11 %h 1",
                     k, n_got, g_key[0], g_last[10], key_a(10));
        end
    endtask

    initial begin
        test_reset();
        test_start_no_cache();
        test_forward();
        test_reverse();
        test_back_to_back();
        test_backpressure();
        test_start_during_expand();
        test_abort();
        test_reset_mid_expand();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer for AES-128 round keys. On `load`, it runs the one-step key expansion for 10 cycles and stores all 11 round keys in an internal cache. On `start`, it streams the cached keys to the cipher/decipher datapath over a valid/ready handshake, in forward order (round 0→10) or reverse order (round 10→0). Encryption and decryption of many blocks under one key then reuse the cache without re-expanding.

## Interface
Parameters:
- `NR`, 10: number of rounds; cache depth is `NR+1`.
- `KW`, 128: key/round-key width in bits.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `load`  in  1  one-cycle pulse; captures `key`, invalidates cache, starts expansion.
- `key`  in  128  cipher key; sampled only when `load`=1.
- `start`  in  1  one-cycle pulse; begins a round-key stream from the cache.
- `dir`  in  1  stream order, sampled with `start`: 0 = forward, 1 = reverse.
- `rk_ready`  in  1  consumer accepts `rk` this cycle.
- `rk_valid`  out  1  `rk`, `rk_round` and `rk_last` are valid.
- `rk`  out  128  current round key, word 0 in bits [127:96].
- `rk_round`  out  4  round index of `rk` (0..10).
- `rk_last`  out  1  `rk` is the final key of the stream (round 10 forward, round 0 reverse).
- `busy`  out  1  expansion in progress.
- `cache_ok`  out  1  cache holds a complete schedule for the last loaded key.

## Operation
- FSM states: IDLE, EXPAND, STREAM.
- Reset values:
  - State IDLE.
  - `rk_valid`=0, `rk`=0, `rk_round`=0, `rk_last`=0, `busy`=0, `cache_ok`=0.
  - Cache contents are not reset.
- `load` in any state: go to EXPAND.
  - `cache[0]`←`key`; working key←`key`; counter←1.
  - `cache_ok`←0, `busy`←1, `rk_valid`←0. Any active stream is aborted.
- EXPAND, one step per cycle:
  - `cache[cnt]`←step(working key, Rcon[cnt]); working key←same value; cnt++.
  - After the write of `cnt`=10: go to IDLE with `busy`←0, `cache_ok`←1.
- step(): RotWord, then SubWord, on word 3; XOR with Rcon; then the XOR chain w0..w3 per FIPS-197.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, in the MSB byte.
- `start` in IDLE with `cache_ok`=1: go to STREAM.
  - idx←0 if `dir`=0, else 10.
  - Present `cache[idx]` with `rk_valid`=1.
- `start` is ignored when the state is not IDLE or `cache_ok`=0. No error flag.
- STREAM transfer: occurs on `rk_valid & rk_ready`.
  - On a transfer, idx steps by ±1 and the outputs update on the next edge.
  - On the transfer with `rk_last`=1: `rk_valid`←0, go to IDLE.
- Outputs `rk`, `rk_round` and `rk_last` hold stable while `rk_valid=1 & rk_ready=0`.
- Simultaneous `load` and `start`: `load` wins; `start` is dropped.
- `reset` mid-EXPAND or mid-STREAM: return to reset values. `cache_ok`=0 until the next full expansion.
- Arithmetic: idx and cnt are 4-bit; cnt never exceeds 10; no wrap.

## Timing
- `load` at edge t:
  - `busy`=1 from t+1.
  - Last cache write at t+10.
  - `cache_ok`=1 and `busy`=0 from t+11.
- `start` at edge t: `rk_valid`=1 with the first key from t+1. Output is registered; cache read is synchronous.
- Throughput: one key per cycle with `rk_ready` held high. A full stream takes 11 cycles; `rk_valid` falls at t+12.
- No combinational path from `rk_ready` to `rk` or `rk_valid`.
- `start` is accepted in the cycle `rk_valid` falls back to IDLE (i.e. t+12 in the example above). Gap between streams is 1 cycle minimum.

## Structure
- Shared package `aes_pkg`:
  - `NR`, `KW`.
  - `rcon_t` table of 10 bytes.
  - Typedef `rkey_t` (logic [127:0]).
  - FSM enum `ks_state_t`.
- Sub-module `aes_key_step`: combinational one-round expansion (prev key + Rcon index → next key). It instantiates the team's existing RotWord/SubWord blocks.
- Cache: 11×128 register array, single write port (EXPAND) and single read port (STREAM).

## Test plan
- FIPS-197 forward stream:
  - Stimulus: `load` key 2b7e1516 28aed2a6 abf71588 09cf4f3c; wait for `cache_ok`; `start` `dir`=0 with `rk_ready`=1.
  - Required: 11 transfers on consecutive cycles. Round 1 = a0fafe17 88542cb1 23a33939 2a6c7605; round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with `rk_last`=1.
  - Required: `cache_ok` rises exactly 11 cycles after `load`.
- Reverse stream, same key:
  - Stimulus: `start` `dir`=1.
  - Required: first key is round 10 (d014f9a8…); last key is round 0 (2b7e1516…) with `rk_last`=1. No re-expansion occurs (`busy` stays 0).
- Backpressure:
  - Stimulus: toggle `rk_ready` randomly during a stream.
  - Required: `rk` and `rk_round` stable while stalled; no key skipped or duplicated; `rk_round` sequence is exactly 0..10.
- Ignored `start`:
  - Stimulus: `start` during EXPAND, and `start` after reset before any `load`.
  - Required: `rk_valid` stays 0; state unchanged.
- Abort:
  - Stimulus: `load` of a new key mid-STREAM, plus same-cycle `load`+`start`.
  - Required: `rk_valid`=0 next cycle; `busy`=1; the new schedule is correct after 11 cycles.
- Reset mid-EXPAND:
  - Stimulus: `reset` at cycle 5 of EXPAND.
  - Required: all outputs at reset values; `start` is ignored until a new `load` completes.
